// File: rtl/dm_decoder_seq.sv
// Registered 4-to-16 style decoder with address latch, prescaled scan counter and TC pulse.
// Active-low one-hot selects come from the latched address or the scan counter.
module dm_decoder_seq #(
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                g1_ni,
    input  logic                g2_ni,
    input  logic                le_ni,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                mode_i,
    input  logic                step_i,
    input  logic                load_i,
    output logic [2**SEL_W-1:0] y_no,
    output logic [SEL_W-1:0]    cnt_o,
    output logic                tc_o
);

    localparam int unsigned OUT_N = 2 ** SEL_W;
    // Keep at least one bit so STEP_DIV=1 still elaborates; the register then stays 0.
    localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PreLast = PRE_W'(STEP_DIV - 1);
    localparam logic [SEL_W-1:0] CntLast = SEL_W'(OUT_N - 1);

    logic [SEL_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             en_q, en_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic [SEL_W-1:0] idx;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            addr_q <= '0;
            cnt_q  <= '0;
            pre_q  <= '0;
            en_q   <= 1'b0;
            mode_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            tc_q   <= tc_d;
        end
    end

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        tc_d   = 1'b0;
        en_d   = !g1_ni && !g2_ni;
        mode_d = mode_i;

        if (!le_ni) begin
            addr_d = sel_i;
        end

        // LOAD wins over STEP and ignores MODE.
        if (load_i) begin
            cnt_d = sel_i;
            pre_d = '0;
        end else if (step_i && mode_i) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                cnt_d = cnt_q + 1'b1;
                tc_d  = (cnt_q == CntLast);
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_comb begin
        idx  = mode_q ? cnt_q : addr_q;
        y_no = '1;
        if (en_q) begin
            y_no[idx] = 1'b0;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule

// File: tb/tb_dm_decoder_seq.sv
// Bench for dm_decoder_seq: two instances (STEP_DIV=1 and 3) on shared stimulus, checked
// every cycle against an arithmetic model, plus directed literal expectations.
module tb_dm_decoder_seq;

    localparam int unsigned SEL_W = 4;
    localparam int unsigned OUT_N = 16;

    logic              clk;
    logic              reset_n;
    logic              g1_n, g2_n, le_n, mode, step, load;
    logic [SEL_W-1:0]  sel;
    logic [OUT_N-1:0]  y1_n, y3_n;
    logic [SEL_W-1:0]  cnt1, cnt3;
    logic              tc1, tc3;

    int n_checks = 0;
    int n_errors = 0;

    dm_decoder_seq #(.SEL_W(SEL_W), .STEP_DIV(1)) u_dut1 (
        .clk_i(clk), .reset_ni(reset_n), .g1_ni(g1_n), .g2_ni(g2_n), .le_ni(le_n),
        .sel_i(sel), .mode_i(mode), .step_i(step), .load_i(load),
        .y_no(y1_n), .cnt_o(cnt1), .tc_o(tc1)
    );

    dm_decoder_seq #(.SEL_W(SEL_W), .STEP_DIV(3)) u_dut3 (
        .clk_i(clk), .reset_ni(reset_n), .g1_ni(g1_n), .g2_ni(g2_n), .le_ni(le_n),
        .sel_i(sel), .mode_i(mode), .step_i(step), .load_i(load),
        .y_no(y3_n), .cnt_o(cnt3), .tc_o(tc3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Counter modelled as load value plus qualified steps since the last load, divided down.
    bit m_started = 0;
    bit m_en = 0, m_mode = 0, m_tc1 = 0, m_tc3 = 0;
    int m_addr = 0, m_base = 0, m_steps = 0;

    function automatic int m_cnt(input int div);
        return (m_base + m_steps / div) % OUT_N;
    endfunction

    function automatic logic [31:0] m_y(input int div);
        int idx;
        logic [31:0] v;
        idx = m_mode ? m_cnt(div) : m_addr;
        v = 32'h0000_FFFF;
        if (m_en) v = v & ~(32'h1 << idx);
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_started = 1;
            m_addr = 0; m_base = 0; m_steps = 0;
            m_en = 0; m_mode = 0; m_tc1 = 0; m_tc3 = 0;
        end else begin
            m_en   = !g1_n && !g2_n;
            m_mode = mode;
            if (!le_n) m_addr = int'(sel);
            m_tc1 = 0;
            m_tc3 = 0;
            if (load) begin
                m_base  = int'(sel);
                m_steps = 0;
            end else if (step && mode) begin
                m_steps++;
                m_tc1 = (m_cnt(1) == 0);
                m_tc3 = (m_steps % 3 == 0) && (m_cnt(3) == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("y_div1",   32'(y1_n), m_y(1));
            check("cnt_div1", 32'(cnt1), 32'(m_cnt(1)));
            check("tc_div1",  32'(tc1),  32'(m_tc1));
            check("y_div3",   32'(y3_n), m_y(3));
            check("cnt_div3", 32'(cnt3), 32'(m_cnt(3)));
            check("tc_div3",  32'(tc3),  32'(m_tc3));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int pre_exp[7] = '{0, 0, 1, 1, 1, 2, 2};

    initial begin
        reset_n = 1'b0; g1_n = 1'b1; g2_n = 1'b1; le_n = 1'b1;
        sel = '0; mode = 1'b0; step = 1'b0; load = 1'b0;

        // Reset and address latch
        tick(); tick();
        check("lit_rst_y", 32'(y1_n), 32'hFFFF);
        check("lit_rst_cnt", 32'(cnt1), 32'd0);
        check("lit_rst_tc", 32'(tc1), 32'd0);
        reset_n = 1'b1; g1_n = 1'b0; g2_n = 1'b0; le_n = 1'b0; sel = 4'd5;
        tick();
        check("lit_latch5", 32'(y1_n), 32'hFFDF);
        le_n = 1'b1; sel = 4'd9;
        tick();
        check("lit_hold", 32'(y1_n), 32'hFFDF);

        // Strobe gating
        g2_n = 1'b1;
        tick();
        check("lit_blank", 32'(y1_n), 32'hFFFF);
        g2_n = 1'b0;
        tick();
        check("lit_unblank", 32'(y1_n), 32'hFFDF);

        // Scan and wrap, STEP_DIV=1
        mode = 1'b1; load = 1'b1; sel = 4'd14;
        tick();
        check("lit_load14", 32'(y1_n), 32'hBFFF);
        load = 1'b0; step = 1'b1;
        tick();
        check("lit_scan15_cnt", 32'(cnt1), 32'd15);
        check("lit_scan15_y", 32'(y1_n), 32'h7FFF);
        check("lit_scan15_tc", 32'(tc1), 32'd0);
        tick();
        check("lit_scan0_cnt", 32'(cnt1), 32'd0);
        check("lit_scan0_y", 32'(y1_n), 32'hFFFE);
        check("lit_scan0_tc", 32'(tc1), 32'd1);
        tick();
        check("lit_scan1_y", 32'(y1_n), 32'hFFFD);
        check("lit_scan1_tc", 32'(tc1), 32'd0);

        // LOAD beats STEP
        load = 1'b1; sel = 4'd15;
        tick();
        check("lit_prio_cnt", 32'(cnt1), 32'd15);
        check("lit_prio_tc", 32'(tc1), 32'd0);
        load = 1'b0;
        tick();
        check("lit_prio_wrap_cnt", 32'(cnt1), 32'd0);
        check("lit_prio_wrap_tc", 32'(tc1), 32'd1);
        step = 1'b0;
        tick();

        // Prescaler on the STEP_DIV=3 instance
        load = 1'b1; sel = 4'd0;
        tick();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step = 1'b1; tick();
            step = 1'b0; tick();
            check("lit_pre_cnt", 32'(cnt3), 32'(pre_exp[i]));
        end
        load = 1'b1; sel = 4'd2;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick();
            step = 1'b0; tick();
            check("lit_pre_reload", 32'(cnt3), (i == 2) ? 32'd3 : 32'd2);
        end

        // Reset mid-scan wins over LOAD/STEP/LE_N
        load = 1'b1; sel = 4'd7;
        tick();
        check("lit_load7", 32'(cnt1), 32'd7);
        load = 1'b1; step = 1'b1; le_n = 1'b0; sel = 4'd3; reset_n = 1'b0;
        tick();
        check("lit_midrst_cnt", 32'(cnt1), 32'd0);
        check("lit_midrst_tc", 32'(tc1), 32'd0);
        check("lit_midrst_y", 32'(y1_n), 32'hFFFF);
        reset_n = 1'b1; load = 1'b0; step = 1'b0; le_n = 1'b1;

        // Randomised phase, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            g1_n    = ($urandom_range(0, 7) == 0);
            g2_n    = ($urandom_range(0, 7) == 0);
            le_n    = $urandom_range(0, 1) != 0;
            sel     = SEL_W'($urandom_range(0, OUT_N - 1));
            mode    = ($urandom_range(0, 3) != 0);
            step    = $urandom_range(0, 1) != 0;
            load    = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_decoder_seq.md
# dm_decoder_seq

Parametrised, registered successor to the 4-line to 16-line TTL decoders used across the discrete-logic game cores. It adds an address latch, a built-in scan counter with prescaler and terminal-count output, and registered strobe qualification. It drives active-low one-hot selects for playfield/score multiplexing, either from an externally latched address or from a self-advancing sequence.

## Interface
- SEL_W, 4: select width; output count OUT_N = 2**SEL_W (legal 1..6).
- STEP_DIV, 1: STEP pulses per scan-counter advance (legal 1..256).

- CLK  in  1  system clock; all state changes on rising edge.
- RESET_N  in  1  reset, synchronous and active-low.
- G1_N  in  1  strobe, active low.
- G2_N  in  1  strobe, active low; outputs enabled only when G1_N and G2_N are both low.
- LE_N  in  1  address latch enable, active low; low = sample SEL, high = hold.
- SEL  in  SEL_W  decode address; also load value for the scan counter.
- MODE  in  1  0 = decode latched address, 1 = decode scan counter.
- STEP  in  1  scan advance request, one per cycle max, honoured only when MODE=1.
- LOAD  in  1  load scan counter from SEL, clear prescaler.
- Y_N  out  OUT_N  active-low one-hot outputs; bit k low selects line k.
- CNT  out  SEL_W  current scan counter value.
- TC  out  1  terminal count, one-cycle high pulse on counter wrap.

## Operation
- State registers, with reset values: addr_q=0, cnt_q=0, pre_q=0, en_q=0, mode_q=0, tc_q=0.
- Every edge: en_q <= (!G1_N && !G2_N); mode_q <= MODE.
- Address latch: LE_N=0 -> addr_q <= SEL; LE_N=1 -> hold.
- Scan counter, priority order:
  - LOAD=1: cnt_q <= SEL, pre_q <= 0, tc_q <= 0. LOAD overrides simultaneous STEP and is independent of MODE.
  - else STEP=1 and MODE=1:
    - pre_q = STEP_DIV-1: pre_q <= 0, cnt_q <= cnt_q+1 modulo OUT_N, tc_q <= 1 iff cnt_q = OUT_N-1, else 0.
    - otherwise: pre_q <= pre_q+1, tc_q <= 0.
  - else: hold cnt_q and pre_q, tc_q <= 0.
- Output decode, combinational from registers only:
  - idx = mode_q ? cnt_q : addr_q.
  - Y_N = en_q ? ~(1<<idx) : all ones.
- CNT = cnt_q; TC = tc_q.
- With STEP_DIV=1, pre_q is constant 0; every qualified STEP advances the counter.
- MODE switching does not disturb cnt_q, pre_q or addr_q.
- Exactly zero or one Y_N bit is low at all times.

## Timing
- Reset: RESET_N low at an edge forces all registers to reset values at that edge, including mid-scan or mid-latch. Outputs after that edge: Y_N all ones, CNT=0, TC=0. Reset overrides LOAD, STEP and LE_N.
- Latency: a change on G1_N/G2_N, MODE, SEL (with LE_N=0), LOAD or a qualified STEP shows on Y_N/CNT after one edge. No input passes combinationally to any output.
- TC goes high in the same cycle CNT first reads 0 after a wrap. It stays high for exactly one cycle, even if STEP stays high.
- Loading OUT_N-1 and then stepping wraps to 0 with TC=1. Loading 0 never raises TC.
- SEL changes while LE_N=1 have no effect on Y_N in decode mode.
- Strobe deassert (either G high) blanks Y_N after one edge; latch and counter continue to update underneath.

## Test plan
- Reset/latch, SEL_W=4: hold RESET_N=0 for 2 edges -> Y_N=16'hFFFF, CNT=0, TC=0. Release with G1_N=G2_N=0, LE_N=0, SEL=5, MODE=0 -> next cycle Y_N=16'hFFDF. Set LE_N=1, SEL=9 -> Y_N stays 16'hFFDF.
- Strobe gating: from Y_N=16'hFFDF, G2_N=1 for one cycle -> Y_N=16'hFFFF for exactly that following cycle. G2_N=0 -> 16'hFFDF again.
- Scan and wrap, STEP_DIV=1: MODE=1, LOAD with SEL=14, then STEP held 3 cycles -> CNT 15, 0, 1. Y_N goes 16'h7FFF, 16'hFFFE, 16'hFFFD. TC=1 only in the CNT=0 cycle.
- LOAD priority: LOAD=1, STEP=1, SEL=15 simultaneously -> CNT=15, TC=0. Next STEP -> CNT=0, TC=1.
- Prescaler, STEP_DIV=3: from CNT=0, 7 single STEP pulses -> CNT advances after pulses 3 and 6 only, ending at CNT=2. LOAD after pulse 7 clears the prescaler, so 3 further pulses are needed for the next advance.
- Reset mid-scan: CNT=7, STEP high, RESET_N low for one edge -> CNT=0, TC=0, Y_N=16'hFFFF the next cycle, regardless of LOAD/STEP.
